display_tempo: RTL
==================

DISPLAY_TEMPO -- requirements
Module: display_tempo

Interface
REQ-001 SHALL have parameter CONV_BITS, default 10, meaning the width of the seconds input converted by the binary-to-BCD engine.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port cont_seg, input, 10: binary seconds count from the stopwatch counter, valid range 0..999.
REQ-005 SHALL have port cont_dec, input, 4: binary tenths count from the stopwatch counter, valid range 0..9.
REQ-006 SHALL have port limite, input, 1: wrap indication from the stopwatch counter.
REQ-007 SHALL have port hex0, output, 7: tenths digit segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-008 SHALL have port hex1, output, 7: seconds-units digit segments, same encoding.
REQ-009 SHALL have port hex2, output, 7: seconds-tens digit segments, same encoding.
REQ-010 SHALL have port hex3, output, 7: seconds-hundreds digit segments, same encoding.
REQ-011 SHALL have port dp1_n, output, 1: decimal point after hex1, active-low, constant 0 (lit).
REQ-012 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-013 SHALL have port range_err, output, 1: high while the displayed value came from an out-of-range cont_seg.
REQ-014 SHALL have port ovf, output, 1: sticky flag meaning the stopwatch has wrapped.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CONV, LOAD.
REQ-016 IDLE: when {cont_seg,cont_dec} differs from the last-converted value, SHALL capture both inputs, clear the shift count and enter CONV; otherwise SHALL stay in IDLE.
REQ-017 CONV: each cycle SHALL perform one double-dabble step (add 3 to every BCD nibble >= 5, then shift left 1); after exactly CONV_BITS steps SHALL enter LOAD.
REQ-018 LOAD: SHALL register hex3..hex0 from the BCD digits and the captured tenths, update the last-converted value, and return to IDLE.
REQ-019 Latency: outputs SHALL update on the 12th rising edge after the IDLE edge that captures the inputs (1 capture + 10 CONV + 1 LOAD).
REQ-020 busy SHALL be 1 in CONV and LOAD and 0 in IDLE.
REQ-021 Input changes during CONV/LOAD SHALL NOT affect the running conversion; they SHALL be detected on return to IDLE; outputs SHALL never show a mix of two samples.
REQ-022 cont_seg in 1000..1023 SHALL display 9,9,9 on hex3..hex1 and set range_err at LOAD; an in-range conversion SHALL clear range_err at LOAD.
REQ-023 cont_dec in 10..15 SHALL display a dash (7'b0111111) on hex0.
REQ-024 Digit codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 ovf SHALL be set on any rising edge with limite=1 and SHALL be held until reset, independent of FSM state.

Reset
REQ-026 On reset=1 the block SHALL immediately (asynchronously) go to IDLE: busy=0, range_err=0, ovf=0, last-converted value=0, hex3..hex0 showing 0, including mid-conversion.
REQ-027 After reset is released with nonzero inputs, the first IDLE edge SHALL start a conversion.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN defined: hex3 SHALL be blank (7'b1111111) when the hundreds digit is 0, and hex2 SHALL be blank when the hundreds and tens digits are both 0; hex1 and hex0 SHALL never be blanked; the reset value of hex3 and hex2 SHALL be blank.
REQ-029 LEADING_ZERO_BLANK_EN undefined: all four digits SHALL always be shown, including leading zeros.

Verification
REQ-030 Assert and release reset with inputs 0 -> hex3..hex0=1000000 (hex3/hex2 blank with the macro), busy=0, ovf=0.
REQ-031 Set cont_seg=123, cont_dec=4 -> busy=1 for 11 cycles; after 12 edges hex3=1111001, hex2=0100100, hex1=0110000, hex0=0011001.
REQ-032 Set cont_seg=1000, then cont_seg=5 -> first result is hex3..hex1 showing 9,9,9 with range_err=1; second result is hex1=0010010 with range_err=0.
REQ-033 Change input from 123 to 456 at CONV step 3 -> 1,2,3 is shown first, then 4,5,6 twelve edges after return to IDLE; no intermediate digit values appear.
REQ-034 Pulse limite for one cycle, then hold it low -> ovf=1 until reset; asserting reset mid-CONV -> reset values immediately.
REQ-035 Set cont_dec=12 -> hex0=0111111 after the conversion completes.

Source files
------------

// File: rtl/display_tempo.sv
// display_tempo
//   Converts the stopwatch's binary seconds count into three BCD digits
//   with a serial double-dabble engine, one shift step per clock. The
//   finished digits and the tenths count drive four active-low 7-segment
//   displays.
//
//   Configuration macro: LEADING_ZERO_BLANK_EN
//     defined   - leading-zero hundreds/tens digits are blanked
//     undefined - all four digits always show, leading zeros included
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   cont_seg   in   [9:0] binary seconds, valid 0..999
//   cont_dec   in   [3:0] binary tenths, valid 0..9
//   limite     in   wrap pulse from the stopwatch counter
//   hex0..hex3 out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//                   (hex0 tenths, hex1 units, hex2 tens, hex3 hundreds)
//   dp1_n      out  decimal point after hex1, always lit (0)
//   busy       out  conversion in progress (CONV or LOAD)
//   range_err  out  displayed value came from cont_seg >= 1000
//   ovf        out  sticky wrap flag, cleared only by reset
//
// Handshake: there is none. The block samples {cont_seg,cont_dec} in IDLE
// whenever it differs from the last value converted; inputs that change
// while busy are picked up once the block is back in IDLE.
module display_tempo #(
  parameter int CONV_BITS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] cont_seg,
  input  logic [3:0] cont_dec,
  input  logic       limite,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       dp1_n,
  output logic       busy,
  output logic       range_err,
  output logic       ovf
);

  localparam int         CNT_W     = $clog2(CONV_BITS + 1);
  localparam logic [6:0] HEX_ZERO  = 7'b1000000;
  localparam logic [6:0] HEX_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX_LEAD_RST = HEX_BLANK;
`else
  localparam logic [6:0] HEX_LEAD_RST = HEX_ZERO;
`endif

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     step_cnt;
  logic [9:0]           cap_seg;
  logic [3:0]           cap_dec;
  logic [13:0]          last_val;
  logic [CONV_BITS-1:0] bin_sr;
  // bit 12 catches a carry out of the hundreds nibble (value >= 1000)
  logic [12:0]          bcd_sr;
  logic [11:0]          bcd_adj;
  logic                 new_sample, last_step;
  logic                 capture, step, load;
  logic                 out_of_range;
  logic [3:0]           dig_h, dig_t, dig_u;

  // Codes for 0..9; anything above 9 shows a dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  assign new_sample = ({cont_seg, cont_dec} != last_val);
  assign last_step  = (step_cnt == CNT_W'(CONV_BITS - 1));

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (new_sample) state_next = CONV;
      CONV:    if (last_step)  state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs / datapath strobes
  always_comb begin
    busy    = (state != IDLE);
    capture = (state == IDLE) && new_sample;
    step    = (state == CONV);
    load    = (state == LOAD);
  end

  // Double-dabble correction: +3 on every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      else                          bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4];
    end
  end

  // Out-of-range seconds are pinned to 999 rather than showing garbage.
  always_comb begin
    out_of_range = (cap_seg >= 10'd1000) || bcd_sr[12];
    if (out_of_range) begin
      dig_h = 4'd9;
      dig_t = 4'd9;
      dig_u = 4'd9;
    end else begin
      dig_h = bcd_sr[11:8];
      dig_t = bcd_sr[7:4];
      dig_u = bcd_sr[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt  <= '0;
      cap_seg   <= '0;
      cap_dec   <= '0;
      last_val  <= '0;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      hex0      <= HEX_ZERO;
      hex1      <= HEX_ZERO;
      hex2      <= HEX_LEAD_RST;
      hex3      <= HEX_LEAD_RST;
      range_err <= 1'b0;
    end else if (capture) begin
      cap_seg  <= cont_seg;
      cap_dec  <= cont_dec;
      bin_sr   <= CONV_BITS'(cont_seg);
      bcd_sr   <= '0;
      step_cnt <= '0;
    end else if (step) begin
      bcd_sr   <= {bcd_sr[12] | bcd_adj[11], bcd_adj[10:0], bin_sr[CONV_BITS-1]};
      bin_sr   <= bin_sr << 1;
      step_cnt <= step_cnt + CNT_W'(1);
    end else if (load) begin
      // All four digits register together, so a display never mixes samples.
      last_val  <= {cap_seg, cap_dec};
      hex0      <= seg7(cap_dec);
      hex1      <= seg7(dig_u);
`ifdef LEADING_ZERO_BLANK_EN
      hex3      <= (dig_h == 4'd0) ? HEX_BLANK : seg7(dig_h);
      hex2      <= (dig_h == 4'd0 && dig_t == 4'd0) ? HEX_BLANK : seg7(dig_t);
`else
      hex3      <= seg7(dig_h);
      hex2      <= seg7(dig_t);
`endif
      range_err <= out_of_range;
    end
  end

  // Wrap flag is independent of the conversion FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ovf <= 1'b0;
    else if (limite) ovf <= 1'b1;
  end

  assign dp1_n = 1'b0;

endmodule
